tl45_memory: RTL and testbench

Memory-access stage of the TL45 pipeline. It sits directly downstream of the ALU/branch stage and upstream of writeback. Non-memory results pass through with one cycle of latency. Loads and stores run as single-word transfers on a pipelined Wishbone master port, and the stage stalls the upstream pipeline until each transfer completes.

---
 rtl/tl45_pkg.sv | 20 ++
 rtl/tl45_wb_master.sv | 107 ++++++++++
 rtl/tl45_memory.sv | 170 +++++++++++++++++
 tb/tb_tl45_memory.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl45_pkg.sv
// rtl/tl45_pkg.sv - shared TL45 opcodes and memory-stage state encoding
package tl45_pkg;

    localparam logic [4:0] OP_NOP = 5'h00;
    localparam logic [4:0] OP_ADD = 5'h01;
    localparam logic [4:0] OP_BR  = 5'h0C;
    localparam logic [4:0] OP_LW  = 5'h0E;
    localparam logic [4:0] OP_SW  = 5'h0F;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2
    } mem_state_e;

    function automatic logic is_mem_op(input logic [4:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/tl45_wb_master.sv
// rtl/tl45_wb_master.sv - single-word pipelined Wishbone request/response engine
module tl45_wb_master #(
    parameter int AW = 30
) (
    input  logic          clk_i,
    input  logic          resetn_i,
    input  logic          start_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [AW-1:0] wb_addr_o,
    output logic [31:0]   wb_data_o,
    input  logic          wb_ack_i,
    input  logic          wb_stall_i,
    input  logic          wb_err_i
);
    import tl45_pkg::*;

    mem_state_e    state_q, state_d;
    logic          cyc_q, cyc_d;
    logic          stb_q, stb_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   data_q, data_d;

    // Bus state register; reset drops cyc/stb immediately, abandoning any transfer
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q <= MEM_IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Handshake: issue, hold stb through slave stall, then wait for ack/err (err wins)
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        done_o  = 1'b0;
        err_o   = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (start_i) begin
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = we_i;
                    addr_d  = addr_i;
                    data_d  = wdata_i;
                    state_d = MEM_REQ;
                end
            end
            MEM_REQ: begin
                if (!wb_stall_i) begin
                    stb_d   = 1'b0;
                    state_d = MEM_WAIT;
                    if (wb_err_i || wb_ack_i) begin
                        cyc_d   = 1'b0;
                        state_d = MEM_IDLE;
                        err_o   = wb_err_i;
                        done_o  = !wb_err_i;
                    end
                end
            end
            MEM_WAIT: begin
                if (wb_err_i || wb_ack_i) begin
                    cyc_d   = 1'b0;
                    state_d = MEM_IDLE;
                    err_o   = wb_err_i;
                    done_o  = !wb_err_i;
                end
            end
            default: begin
                state_d = MEM_IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
            end
        endcase
    end

    assign busy_o    = (state_q != MEM_IDLE);
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = stb_q;
    assign wb_we_o   = we_q;
    assign wb_addr_o = addr_q;
    assign wb_data_o = data_q;

endmodule

// File: rtl/tl45_memory.sv
// rtl/tl45_memory.sv - TL45 memory-access pipeline stage
module tl45_memory #(
    parameter int AW = 30
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_pipe_stall,
    output logic          o_pipe_stall,
    input  logic [4:0]    i_opcode,
    input  logic [3:0]    i_dr,
    input  logic [31:0]   i_value,
    input  logic [31:0]   i_st_val,
    output logic [3:0]    o_dr,
    output logic [31:0]   o_value,
    output logic [3:0]    o_of_reg,
    output logic [31:0]   o_of_val,
    output logic          o_of_valid,
    output logic          o_bus_err,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    output logic          o_wb_we,
    output logic [AW-1:0] o_wb_addr,
    output logic [31:0]   o_wb_data,
    output logic [3:0]    o_wb_sel,
    input  logic          i_wb_ack,
    input  logic          i_wb_stall,
    input  logic          i_wb_err,
    input  logic [31:0]   i_wb_data
);
    import tl45_pkg::*;

    logic        is_lw, is_mem, aligned;
    logic        busy, mst_done, mst_err, complete;
    logic        mem_go, start;

    logic [3:0]  dr_q, dr_d;
    logic [31:0] value_q, value_d;
    logic        bus_err_q, bus_err_d;
    // Set once the held upstream instruction has finished its transfer, so it is not re-issued
    logic        done_q, done_d;
    logic        lw_q, lw_d;
    logic [3:0]  tdr_q, tdr_d;
    logic        pend_valid_q, pend_valid_d;
    logic [3:0]  pend_dr_q, pend_dr_d;
    logic [31:0] pend_value_q, pend_value_d;
    logic [3:0]  res_dr;
    logic [31:0] res_value;

    assign is_lw    = (i_opcode == OP_LW);
    assign is_mem   = is_mem_op(i_opcode);
    assign aligned  = (i_value[1:0] == 2'b00);
    assign complete = mst_done | mst_err;
    assign mem_go   = !busy && is_mem && aligned && !done_q;
    assign start    = mem_go && !i_pipe_stall;

    assign o_pipe_stall = i_pipe_stall | mem_go | busy;

    tl45_wb_master #(.AW(AW)) u_wb (
        .clk_i      (i_clk),
        .resetn_i   (i_reset),
        .start_i    (start),
        .we_i       (i_opcode == OP_SW),
        .addr_i     (i_value[AW+1:2]),
        .wdata_i    (i_st_val),
        .busy_o     (busy),
        .done_o     (mst_done),
        .err_o      (mst_err),
        .wb_cyc_o   (o_wb_cyc),
        .wb_stb_o   (o_wb_stb),
        .wb_we_o    (o_wb_we),
        .wb_addr_o  (o_wb_addr),
        .wb_data_o  (o_wb_data),
        .wb_ack_i   (i_wb_ack),
        .wb_stall_i (i_wb_stall),
        .wb_err_i   (i_wb_err)
    );

    // Stage output, error flag, in-flight transfer context and stalled-completion buffer
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            dr_q         <= '0;
            value_q      <= '0;
            bus_err_q    <= 1'b0;
            done_q       <= 1'b0;
            lw_q         <= 1'b0;
            tdr_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_dr_q    <= '0;
            pend_value_q <= '0;
        end else begin
            dr_q         <= dr_d;
            value_q      <= value_d;
            bus_err_q    <= bus_err_d;
            done_q       <= done_d;
            lw_q         <= lw_d;
            tdr_q        <= tdr_d;
            pend_valid_q <= pend_valid_d;
            pend_dr_q    <= pend_dr_d;
            pend_value_q <= pend_value_d;
        end
    end

    // Next-state: pass-through, bubbles for memory ops, completion capture or buffering
    always_comb begin
        dr_d         = dr_q;
        value_d      = value_q;
        bus_err_d    = bus_err_q;
        done_d       = done_q;
        lw_d         = lw_q;
        tdr_d        = tdr_q;
        pend_valid_d = pend_valid_q;
        pend_dr_d    = pend_dr_q;
        pend_value_d = pend_value_q;
        res_dr       = '0;
        res_value    = value_q;

        if (start) begin
            lw_d  = is_lw;
            tdr_d = i_dr;
        end

        if (complete) begin
            done_d = 1'b1;
            if (mst_err) begin
                bus_err_d = 1'b1;
            end else if (lw_q) begin
                res_dr    = tdr_q;
                res_value = i_wb_data;
            end
            if (i_pipe_stall) begin
                pend_valid_d = 1'b1;
                pend_dr_d    = res_dr;
                pend_value_d = res_value;
            end else begin
                dr_d    = res_dr;
                value_d = res_value;
            end
        end else begin
            if (!o_pipe_stall) begin
                done_d = 1'b0;
            end
            if (!busy && !i_pipe_stall) begin
                if (pend_valid_q) begin
                    dr_d         = pend_dr_q;
                    value_d      = pend_value_q;
                    pend_valid_d = 1'b0;
                end else if (done_q) begin
                    dr_d = '0;
                end else if (is_mem) begin
                    dr_d = '0;
                    if (!aligned) begin
                        bus_err_d = 1'b1;
                    end
                end else begin
                    dr_d    = i_dr;
                    value_d = i_value;
                end
            end
        end
    end

    assign o_dr       = dr_q;
    assign o_value    = value_q;
    assign o_bus_err  = bus_err_q;
    assign o_wb_sel   = 4'hF;
    assign o_of_reg   = i_dr;
    assign o_of_val   = is_mem ? value_q : i_value;
    assign o_of_valid = !is_mem || (is_lw && done_q && !pend_valid_q);

endmodule

// File: tb/tb_tl45_memory.sv
// tb/tb_tl45_memory.sv - scoreboard bench for the TL45 memory stage
module tb_tl45_memory;
    import tl45_pkg::*;

    localparam int K_OUT = 0, K_DR = 1, K_STALL = 2, K_ERR = 3, K_BUS = 4, K_FWD = 5;

    typedef struct packed {
        logic [31:0] tag;
        logic [2:0]  kind;
        logic [7:0]  id;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    typedef struct packed {
        logic [29:0] addr;
        logic        we;
        logic [31:0] data;
    } req_t;

    logic        i_clk, i_reset, i_pipe_stall, o_pipe_stall;
    logic [4:0]  i_opcode;
    logic [3:0]  i_dr, o_dr, o_of_reg;
    logic [31:0] i_value, i_st_val, o_value, o_of_val;
    logic        o_of_valid, o_bus_err;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [29:0] o_wb_addr;
    logic [31:0] o_wb_data, i_wb_data;
    logic [3:0]  o_wb_sel;
    logic        i_wb_ack, i_wb_stall, i_wb_err;

    exp_t exp_q[$];
    req_t req_q[$];
    int   total = 0;
    int   bad = 0;
    int   cnum = 0;
    int   cur = 0;
    int   tid = 0;

    int          sl_stall_left = 0;
    logic        sl_err = 1'b0;
    logic        sl_noack = 1'b0;
    logic        sl_pend = 1'b0;
    logic [31:0] sl_rdata = '0;

    tl45_memory #(.AW(30)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_pipe_stall(i_pipe_stall), .o_pipe_stall(o_pipe_stall),
        .i_opcode(i_opcode), .i_dr(i_dr), .i_value(i_value), .i_st_val(i_st_val),
        .o_dr(o_dr), .o_value(o_value), .o_of_reg(o_of_reg), .o_of_val(o_of_val),
        .o_of_valid(o_of_valid), .o_bus_err(o_bus_err),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
        .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    function automatic string kname(input logic [2:0] k);
        case (k)
            3'd0: return "out";
            3'd1: return "dr";
            3'd2: return "stall";
            3'd3: return "err";
            3'd4: return "bus";
            default: return "fwd";
        endcase
    endfunction

    task automatic expect_at(input int tag, input int kind, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.tag  = tag;
        e.kind = kind[2:0];
        e.id   = tid[7:0];
        e.a    = a;
        e.b    = b;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [4:0] op, input logic [3:0] dr, input logic [31:0] v,
                         input logic [31:0] sv, input logic ps);
        @(posedge i_clk);
        #1;
        i_opcode     = op;
        i_dr         = dr;
        i_value      = v;
        i_st_val     = sv;
        i_pipe_stall = ps;
        cur          = cnum + 1;
    endtask

    task automatic push_req(input logic [29:0] addr, input logic we, input logic [31:0] data);
        req_t r;
        r.addr = addr;
        r.we   = we;
        r.data = data;
        req_q.push_back(r);
    endtask

    // Wishbone slave: optional stall count, ack one cycle after acceptance
    initial begin
        i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_stall = 1'b0; i_wb_data = '0;
        forever begin
            @(posedge i_clk);
            #1;
            i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_stall = 1'b0;
            if (sl_pend) begin
                sl_pend = 1'b0;
                if (!sl_noack) begin
                    i_wb_ack  = 1'b1;
                    i_wb_err  = sl_err;
                    i_wb_data = sl_rdata;
                end
            end
            if (o_wb_cyc && o_wb_stb) begin
                if (sl_stall_left > 0) begin
                    i_wb_stall = 1'b1;
                    sl_stall_left--;
                end else begin
                    sl_pend = 1'b1;
                end
            end
        end
    end

    // Monitor: compare due expectations and accepted bus requests each cycle
    initial begin
        forever begin
            @(negedge i_clk);
            cnum++;
            begin
                int i;
                logic        ok;
                logic [31:0] ga, gb;
                i = 0;
                while (i < exp_q.size()) begin
                    if (exp_q[i].tag == cnum) begin
                        gb = '0;
                        case (exp_q[i].kind)
                            3'd0: begin ga = {28'd0, o_dr}; gb = o_value; ok = (ga == exp_q[i].a) && (gb == exp_q[i].b); end
                            3'd1: begin ga = {28'd0, o_dr}; ok = (ga == exp_q[i].a); end
                            3'd2: begin ga = {31'd0, o_pipe_stall}; ok = (ga == exp_q[i].a); end
                            3'd3: begin ga = {31'd0, o_bus_err}; ok = (ga == exp_q[i].a); end
                            3'd4: begin ga = {30'd0, o_wb_cyc, o_wb_stb}; ok = (ga == exp_q[i].a); end
                            default: begin
                                ga = {31'd0, o_of_valid}; gb = o_of_val;
                                ok = (ga == exp_q[i].a) && (!exp_q[i].a[0] || gb == exp_q[i].b);
                            end
                        endcase
                        total++;
                        if (!ok) begin
                            bad++;
                            $display("FAIL %s t%0d cyc=%0d got=%h/%h exp=%h/%h", kname(exp_q[i].kind),
                                     exp_q[i].id, cnum, ga, gb, exp_q[i].a, exp_q[i].b);
                        end
                        exp_q.delete(i);
                    end else if (exp_q[i].tag < cnum) begin
                        total++;
                        bad++;
                        $display("FAIL stale_%s t%0d tag=%0d", kname(exp_q[i].kind), exp_q[i].id, exp_q[i].tag);
                        exp_q.delete(i);
                    end else begin
                        i++;
                    end
                end
            end
            if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
                total++;
                if (req_q.size() == 0) begin
                    bad++;
                    $display("FAIL req_unexpected cyc=%0d addr=%h we=%b", cnum, o_wb_addr, o_wb_we);
                end else begin
                    req_t r;
                    r = req_q.pop_front();
                    if (o_wb_addr != r.addr || o_wb_we != r.we || o_wb_data != r.data || o_wb_sel != 4'hF) begin
                        bad++;
                        $display("FAIL req cyc=%0d got=%h/%b/%h/%h exp=%h/%b/%h/f", cnum,
                                 o_wb_addr, o_wb_we, o_wb_data, o_wb_sel, r.addr, r.we, r.data);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        i_reset = 1'b0; i_pipe_stall = 1'b0; i_opcode = OP_NOP; i_dr = '0; i_value = '0; i_st_val = '0;

        // reset values
        tid = 0;
        issue(OP_NOP, 4'd0, 32'h0, 32'h0, 1'b0);
        issue(OP_ADD, 4'd5, 32'h77, 32'h0, 1'b0);
        n = cur;
        expect_at(n, K_OUT, 32'd0, 32'd0);
        expect_at(n, K_BUS, 32'd0, 32'd0);
        expect_at(n, K_ERR, 32'd0, 32'd0);
        expect_at(n + 1, K_OUT, 32'd0, 32'd0);
        issue(OP_NOP, 4'd0, 32'h0, 32'h0, 1'b0);
        i_reset = 1'b1;

        // non-memory pass-through
        tid = 1;
        issue(OP_ADD, 4'd3, 32'h1234, 32'h0, 1'b0);
        n = cur;
        expect_at(n, K_STALL, 32'd0, 32'd0);
        expect_at(n, K_FWD, 32'd1, 32'h1234);
        expect_at(n + 1, K_OUT, 32'd3, 32'h1234);

        // zero-wait-state load
        tid = 2;
        sl_rdata = 32'hDEADBEEF;
        issue(OP_LW, 4'd5, 32'h100, 32'h5555AAAA, 1'b0);
        n = cur;
        push_req(30'h40, 1'b0, 32'h5555AAAA);
        expect_at(n, K_STALL, 32'd1, 32'd0);
        expect_at(n, K_FWD, 32'd0, 32'd0);
        expect_at(n + 1, K_STALL, 32'd1, 32'd0);
        expect_at(n + 1, K_BUS, 32'd3, 32'd0);
        expect_at(n + 1, K_DR, 32'd0, 32'd0);
        expect_at(n + 2, K_STALL, 32'd1, 32'd0);
        expect_at(n + 2, K_BUS, 32'd2, 32'd0);
        expect_at(n + 3, K_STALL, 32'd0, 32'd0);
        expect_at(n + 3, K_OUT, 32'd5, 32'hDEADBEEF);
        expect_at(n + 4, K_DR, 32'd0, 32'd0);
        expect_at(n + 4, K_BUS, 32'd0, 32'd0);
        repeat (3) issue(OP_LW, 4'd5, 32'h100, 32'h5555AAAA, 1'b0);

        // store with two slave stall cycles
        tid = 3;
        sl_stall_left = 2;
        issue(OP_SW, 4'd7, 32'h204, 32'hCAFEF00D, 1'b0);
        n = cur;
        push_req(30'h81, 1'b1, 32'hCAFEF00D);
        for (int k = 0; k <= 4; k++) expect_at(n + k, K_STALL, 32'd1, 32'd0);
        for (int k = 1; k <= 3; k++) expect_at(n + k, K_BUS, 32'd3, 32'd0);
        expect_at(n + 4, K_BUS, 32'd2, 32'd0);
        expect_at(n + 5, K_STALL, 32'd0, 32'd0);
        expect_at(n + 5, K_BUS, 32'd0, 32'd0);
        expect_at(n + 5, K_DR, 32'd0, 32'd0);
        expect_at(n + 5, K_ERR, 32'd0, 32'd0);
        repeat (5) issue(OP_SW, 4'd7, 32'h204, 32'hCAFEF00D, 1'b0);

        // err and ack together
        tid = 4;
        issue(OP_ADD, 4'd3, 32'h99, 32'h0, 1'b0);
        sl_err = 1'b1;
        issue(OP_LW, 4'd4, 32'h10, 32'h0, 1'b0);
        n = cur;
        push_req(30'h4, 1'b0, 32'h0);
        expect_at(n, K_OUT, 32'd3, 32'h99);
        expect_at(n + 2, K_ERR, 32'd0, 32'd0);
        expect_at(n + 2, K_STALL, 32'd1, 32'd0);
        expect_at(n + 3, K_ERR, 32'd1, 32'd0);
        expect_at(n + 3, K_DR, 32'd0, 32'd0);
        expect_at(n + 3, K_BUS, 32'd0, 32'd0);
        expect_at(n + 3, K_STALL, 32'd0, 32'd0);
        repeat (3) issue(OP_LW, 4'd4, 32'h10, 32'h0, 1'b0);
        sl_err = 1'b0;

        // downstream stall during and after a load
        tid = 5;
        issue(OP_ADD, 4'd1, 32'hAA, 32'h0, 1'b0);
        sl_rdata = 32'h11223344;
        issue(OP_LW, 4'd6, 32'h40, 32'h0, 1'b0);
        n = cur;
        push_req(30'h10, 1'b0, 32'h0);
        expect_at(n, K_OUT, 32'd1, 32'hAA);
        expect_at(n + 3, K_OUT, 32'd0, 32'hAA);
        expect_at(n + 3, K_STALL, 32'd1, 32'd0);
        expect_at(n + 3, K_BUS, 32'd0, 32'd0);
        expect_at(n + 5, K_OUT, 32'd0, 32'hAA);
        expect_at(n + 5, K_STALL, 32'd0, 32'd0);
        expect_at(n + 6, K_OUT, 32'd6, 32'h11223344);
        expect_at(n + 6, K_STALL, 32'd1, 32'd0);
        expect_at(n + 7, K_OUT, 32'd6, 32'h11223344);
        expect_at(n + 8, K_OUT, 32'd8, 32'h77);
        issue(OP_LW, 4'd6, 32'h40, 32'h0, 1'b0);
        repeat (3) issue(OP_LW, 4'd6, 32'h40, 32'h0, 1'b1);
        issue(OP_LW, 4'd6, 32'h40, 32'h0, 1'b0);
        issue(OP_ADD, 4'd8, 32'h77, 32'h0, 1'b1);
        issue(OP_ADD, 4'd8, 32'h77, 32'h0, 1'b0);

        // reset while waiting for ack
        tid = 6;
        issue(OP_ADD, 4'd2, 32'h55, 32'h0, 1'b0);
        sl_noack = 1'b1;
        issue(OP_LW, 4'd9, 32'h20, 32'h0, 1'b0);
        n = cur;
        push_req(30'h8, 1'b0, 32'h0);
        expect_at(n + 2, K_BUS, 32'd2, 32'd0);
        expect_at(n + 2, K_ERR, 32'd1, 32'd0);
        expect_at(n + 3, K_BUS, 32'd0, 32'd0);
        expect_at(n + 3, K_OUT, 32'd0, 32'd0);
        expect_at(n + 3, K_ERR, 32'd0, 32'd0);
        expect_at(n + 3, K_STALL, 32'd0, 32'd0);
        issue(OP_LW, 4'd9, 32'h20, 32'h0, 1'b0);
        issue(OP_LW, 4'd9, 32'h20, 32'h0, 1'b0);
        i_reset = 1'b0;
        issue(OP_NOP, 4'd0, 32'h0, 32'h0, 1'b0);
        i_reset = 1'b1;
        sl_noack = 1'b0;

        // misaligned load
        tid = 7;
        issue(OP_BR, 4'd3, 32'h31, 32'h0, 1'b0);
        issue(OP_LW, 4'd9, 32'h102, 32'h0, 1'b0);
        n = cur;
        expect_at(n, K_STALL, 32'd0, 32'd0);
        expect_at(n, K_ERR, 32'd0, 32'd0);
        expect_at(n, K_OUT, 32'd3, 32'h31);
        expect_at(n + 1, K_BUS, 32'd0, 32'd0);
        expect_at(n + 1, K_ERR, 32'd1, 32'd0);
        expect_at(n + 1, K_DR, 32'd0, 32'd0);
        repeat (3) issue(OP_NOP, 4'd0, 32'h0, 32'h0, 1'b0);

        @(negedge i_clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL exp_left got=%0d exp=0", exp_q.size());
        end
        total++;
        if (req_q.size() != 0) begin
            bad++;
            $display("FAIL req_left got=%0d exp=0", req_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
